// File: rtl/forward_source_pipe.sv
// Producer side of operand forwarding: carries EX results through MEM_REQ, MEM_RESP and WB,
// drives the per-stage forward slots, forms final writeback data and flags load-use hazards.
module forward_source_pipe #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               ex_valid,
    input  logic [RADDR_W-1:0] ex_rd_in,
    input  logic               ex_we_in,
    input  logic               ex_is_load,
    input  logic [2:0]         ex_funct3,
    input  logic [XLEN-1:0]    ex_alu_in,
    input  logic [XLEN-1:0]    mem_resp_rdata,
    input  logic [RADDR_W-1:0] rs1,
    input  logic [RADDR_W-1:0] rs2,
    input  logic               rs1_used,
    input  logic               rs2_used,
    output logic               ex_reg_we,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [XLEN-1:0]    ex_alu_result,
    output logic               mem_req_reg_we,
    output logic [RADDR_W-1:0] mem_req_rd,
    output logic [XLEN-1:0]    mem_req_alu_result,
    output logic               mem_resp_reg_we,
    output logic [RADDR_W-1:0] mem_resp_rd,
    output logic [XLEN-1:0]    mem_resp_alu_result,
    output logic               wb_reg_we,
    output logic [RADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]    writeback,
    output logic               load_use_hazard
);

    logic               ex_live;
    logic               mem_req_ld, mem_resp_ld, wb_ld;
    logic [2:0]         mem_req_f3, mem_resp_f3, wb_f3;
    logic [XLEN-1:0]    wb_alu, wb_rdata;
    logic [XLEN-1:0]    byte_shift, half_shift;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic               ex_ld_hit1, ex_ld_hit2, rs1_hit, rs2_hit;

    // stall outranks flush, so a flush under stall leaves the EX instruction alive
    always_comb begin
        ex_live       = ex_valid & ~(flush & ~stall);
        ex_reg_we     = ex_valid & ex_we_in & (ex_rd_in != '0);
        ex_rd         = ex_rd_in;
        ex_alu_result = ex_alu_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_reg_we      <= 1'b0;
            mem_req_ld          <= 1'b0;
            mem_req_rd          <= '0;
            mem_req_f3          <= '0;
            mem_req_alu_result  <= '0;
            mem_resp_reg_we     <= 1'b0;
            mem_resp_ld         <= 1'b0;
            mem_resp_rd         <= '0;
            mem_resp_f3         <= '0;
            mem_resp_alu_result <= '0;
            wb_reg_we           <= 1'b0;
            wb_ld               <= 1'b0;
            wb_rd               <= '0;
            wb_f3               <= '0;
            wb_alu              <= '0;
            wb_rdata            <= '0;
        end else if (!stall) begin
            mem_req_reg_we      <= ex_live & ex_we_in & (ex_rd_in != '0);
            mem_req_ld          <= ex_live & ex_is_load;
            mem_req_rd          <= ex_rd_in;
            mem_req_f3          <= ex_funct3;
            mem_req_alu_result  <= ex_alu_in;
            mem_resp_reg_we     <= mem_req_reg_we;
            mem_resp_ld         <= mem_req_ld;
            mem_resp_rd         <= mem_req_rd;
            mem_resp_f3         <= mem_req_f3;
            mem_resp_alu_result <= mem_req_alu_result;
            wb_reg_we           <= mem_resp_reg_we;
            wb_ld               <= mem_resp_ld;
            wb_rd               <= mem_resp_rd;
            wb_f3               <= mem_resp_f3;
            wb_alu              <= mem_resp_alu_result;
            if (mem_resp_ld) begin
                wb_rdata <= mem_resp_rdata;
            end
        end
    end

    always_comb begin
        byte_shift = wb_rdata >> {wb_alu[1:0], 3'b000};
        half_shift = wb_rdata >> {wb_alu[1], 4'b0000};
        ld_byte    = byte_shift[7:0];
        ld_half    = half_shift[15:0];
        writeback  = wb_alu;
        if (wb_ld) begin
            case (wb_f3)
                3'b000:  writeback = {{(XLEN-8){ld_byte[7]}}, ld_byte};
                3'b001:  writeback = {{(XLEN-16){ld_half[15]}}, ld_half};
                3'b100:  writeback = {{(XLEN-8){1'b0}}, ld_byte};
                3'b101:  writeback = {{(XLEN-16){1'b0}}, ld_half};
                default: writeback = wb_rdata;
            endcase
        end
    end

    always_comb begin
        ex_ld_hit1 = ex_live & ex_is_load & ex_we_in & (ex_rd_in == rs1);
        ex_ld_hit2 = ex_live & ex_is_load & ex_we_in & (ex_rd_in == rs2);
        rs1_hit = rs1_used & (rs1 != '0) &
                  (ex_ld_hit1 |
                   (mem_req_ld & mem_req_reg_we & (mem_req_rd == rs1)) |
                   (mem_resp_ld & mem_resp_reg_we & (mem_resp_rd == rs1)));
        rs2_hit = rs2_used & (rs2 != '0) &
                  (ex_ld_hit2 |
                   (mem_req_ld & mem_req_reg_we & (mem_req_rd == rs2)) |
                   (mem_resp_ld & mem_resp_reg_we & (mem_resp_rd == rs2)));
        load_use_hazard = rs1_hit | rs2_hit;
    end

endmodule
